tl_client_agent: RTL and testbench

TL_CLIENT_AGENT -- requirements
Module: tl_client_agent

---
 rtl/tl_pkg.sv | 71 +++++++
 rtl/tl_client_agent_if.sv | 94 +++++++++
 rtl/tl_probe_responder.sv | 75 +++++++
 rtl/tl_client_agent.sv | 219 +++++++++++++++++++++
 tb/tb_tl_client_agent.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink constants and types for the client agent.
// Holds channel opcodes, grow/shrink/report permission params, transfer sizes,
// the command-op encoding and the FSM state types used by the agent.
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] OpAPutFullData  = 3'd0;
  localparam logic [2:0] OpAGet          = 3'd4;
  localparam logic [2:0] OpAAcquireBlock = 3'd6;

  // C-channel opcodes
  localparam logic [2:0] OpCProbeAck = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] OpDAccessAck     = 3'd0;
  localparam logic [2:0] OpDAccessAckData = 3'd1;
  localparam logic [2:0] OpDGrant         = 3'd4;
  localparam logic [2:0] OpDGrantData     = 3'd5;

  // Grow params (Acquire)
  localparam logic [2:0] ParamNtoB = 3'd0;
  localparam logic [2:0] ParamNtoT = 3'd1;
  localparam logic [2:0] ParamBtoT = 3'd2;

  // Shrink / report params (Probe ack, Release)
  localparam logic [2:0] ParamTtoB = 3'd0;
  localparam logic [2:0] ParamTtoN = 3'd1;
  localparam logic [2:0] ParamBtoN = 3'd2;
  localparam logic [2:0] ParamTtoT = 3'd3;
  localparam logic [2:0] ParamBtoB = 3'd4;
  localparam logic [2:0] ParamNtoN = 3'd5;

  // log2 of transfer size in bytes
  localparam logic [3:0] SizeBeat  = 4'd3;
  localparam logic [3:0] SizeBlock = 4'd6;

  // Beats in one block transfer (64 B over 8 B beats)
  localparam int unsigned BlockBeats = 8;

  typedef enum logic [1:0] {
    CmdGet     = 2'd0,
    CmdPutFull = 2'd1,
    CmdAcquire = 2'd2,
    CmdRsvd    = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StASend,
    StDWait,
    StESend
  } main_state_e;

  typedef enum logic {
    StPIdle,
    StPAck
  } probe_state_e;

  function automatic logic [2:0] a_opcode_of(cmd_op_e op);
    unique case (op)
      CmdPutFull: return OpAPutFullData;
      CmdAcquire: return OpAAcquireBlock;
      default:    return OpAGet;
    endcase
  endfunction

  function automatic logic [3:0] a_size_of(cmd_op_e op);
    return (op == CmdAcquire) ? SizeBlock : SizeBeat;
  endfunction

endpackage

// File: rtl/tl_client_agent_if.sv
// Bundle of the command/response port and TileLink A-E channels of the agent.
// master: agent view (drives cmd_ready, rsp_*, A/C/E payloads, b_ready, d_ready).
// slave : environment view (drives cmd_*, a_ready, B payload, c_ready, D payload, e_ready).
interface tl_client_agent_if #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SINK_W   = 4
);
  // Command / response
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_param;
  logic [DATA_W-1:0] cmd_data;
  logic [7:0]        cmd_mask;
  logic              rsp_valid;
  logic              rsp_last;
  logic              rsp_denied;
  logic              rsp_timeout;
  logic [DATA_W-1:0] rsp_data;
  // A
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [3:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [7:0]          a_mask;
  logic [DATA_W-1:0]   a_data;
  // B
  logic                b_valid;
  logic                b_ready;
  logic [2:0]          b_opcode;
  logic [2:0]          b_param;
  logic [3:0]          b_size;
  logic [SOURCE_W-1:0] b_source;
  logic [ADDR_W-1:0]   b_address;
  // C
  logic                c_valid;
  logic                c_ready;
  logic [2:0]          c_opcode;
  logic [2:0]          c_param;
  logic [3:0]          c_size;
  logic [SOURCE_W-1:0] c_source;
  logic [ADDR_W-1:0]   c_address;
  logic [DATA_W-1:0]   c_data;
  // D
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [3:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic [SINK_W-1:0]   d_sink;
  logic                d_denied;
  logic [DATA_W-1:0]   d_data;
  // E
  logic              e_valid;
  logic              e_ready;
  logic [SINK_W-1:0] e_sink;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_param, cmd_data, cmd_mask,
    output cmd_ready, rsp_valid, rsp_last, rsp_denied, rsp_timeout, rsp_data,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  b_valid, b_opcode, b_param, b_size, b_source, b_address,
    output b_ready,
    output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
    input  c_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_param, cmd_data, cmd_mask,
    input  cmd_ready, rsp_valid, rsp_last, rsp_denied, rsp_timeout, rsp_data,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output b_valid, b_opcode, b_param, b_size, b_source, b_address,
    input  b_ready,
    input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
    output c_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );
endinterface

// File: rtl/tl_probe_responder.sv
// Answers every B-channel probe with a ProbeAck NtoN on C (the agent keeps no cache
// state), independently of the main transaction FSM.
// Ports: i_clk, i_rst (sync, active-high); B: i_b_valid/o_b_ready/i_b_size/i_b_address;
// C: o_c_valid/i_c_ready and the registered C payload outputs.
module tl_probe_responder
  import tl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SRC_ID   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [3:0]          i_b_size,
  input  logic [ADDR_W-1:0]   i_b_address,
  output logic                o_c_valid,
  input  logic                i_c_ready,
  output logic [2:0]          o_c_opcode,
  output logic [2:0]          o_c_param,
  output logic [3:0]          o_c_size,
  output logic [SOURCE_W-1:0] o_c_source,
  output logic [ADDR_W-1:0]   o_c_address,
  output logic [DATA_W-1:0]   o_c_data
);

  probe_state_e      r_state;
  logic              r_b_ready;
  logic              r_c_valid;
  logic [3:0]        r_size;
  logic [ADDR_W-1:0] r_address;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StPIdle;
      r_b_ready <= 1'b0;
      r_c_valid <= 1'b0;
      r_size    <= '0;
      r_address <= '0;
    end else begin
      unique case (r_state)
        StPIdle: begin
          r_b_ready <= 1'b1;
          if (i_b_valid && r_b_ready) begin
            r_b_ready <= 1'b0;
            r_c_valid <= 1'b1;
            r_size    <= i_b_size;
            r_address <= i_b_address;
            r_state   <= StPAck;
          end
        end
        StPAck: begin
          if (i_c_ready) begin
            r_c_valid <= 1'b0;
            r_b_ready <= 1'b1;
            r_state   <= StPIdle;
          end
        end
        default: r_state <= StPIdle;
      endcase
    end
  end

  assign o_b_ready   = r_b_ready;
  assign o_c_valid   = r_c_valid;
  assign o_c_opcode  = OpCProbeAck;
  assign o_c_param   = ParamNtoN;
  assign o_c_size    = r_size;
  assign o_c_source  = SOURCE_W'(SRC_ID);
  assign o_c_address = r_address;
  assign o_c_data    = '0;

endmodule

// File: rtl/tl_client_agent.sv
// TileLink client agent: turns one command at a time into an A request, collects the
// D response (single beat or 8-beat GrantData burst), finishes Acquires with GrantAck
// on E, and guards D_WAIT with a watchdog. Probes are served by tl_probe_responder.
// Ports: i_clk, i_rst (sync, active-high), io_tl (tl_client_agent_if.master).
module tl_client_agent
  import tl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SINK_W   = 4,
  parameter int unsigned SRC_ID   = 0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic              i_clk,
  input logic              i_rst,
  tl_client_agent_if.master io_tl
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  main_state_e       r_state;
  logic              r_cmd_ready;
  logic              r_a_valid;
  logic [2:0]        r_a_opcode;
  logic [2:0]        r_a_param;
  logic [3:0]        r_a_size;
  logic [ADDR_W-1:0] r_a_address;
  logic [7:0]        r_a_mask;
  logic [DATA_W-1:0] r_a_data;
  logic              r_d_ready;
  logic              r_e_valid;
  logic [SINK_W-1:0] r_e_sink;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_rsp_denied;
  logic              r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_data;
  logic [2:0]        r_beat;
  logic [WdogW-1:0]  r_wdog;

  cmd_op_e w_cmd_op;
  logic    w_d_known_op;
  logic    w_d_match;
  logic    w_unused;

  assign w_cmd_op     = cmd_op_e'(io_tl.cmd_op);
  assign w_d_known_op = (io_tl.d_opcode == OpDAccessAck) || (io_tl.d_opcode == OpDAccessAckData) ||
                        (io_tl.d_opcode == OpDGrant)     || (io_tl.d_opcode == OpDGrantData);
  // Beats for other sources are still handshaken (d_ready=1) but otherwise ignored.
  assign w_d_match    = io_tl.d_valid && r_d_ready && w_d_known_op &&
                        (io_tl.d_source == SOURCE_W'(SRC_ID));
  assign w_unused     = ^{io_tl.d_param, io_tl.d_size, io_tl.b_opcode, io_tl.b_param,
                          io_tl.b_source};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_cmd_ready   <= 1'b0;
      r_a_valid     <= 1'b0;
      r_a_opcode    <= '0;
      r_a_param     <= '0;
      r_a_size      <= '0;
      r_a_address   <= '0;
      r_a_mask      <= '0;
      r_a_data      <= '0;
      r_d_ready     <= 1'b0;
      r_e_valid     <= 1'b0;
      r_e_sink      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_last    <= 1'b0;
      r_rsp_denied  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;
      r_beat        <= '0;
      r_wdog        <= '0;
    end else begin
      // Response strobes are single-cycle pulses.
      r_rsp_valid   <= 1'b0;
      r_rsp_last    <= 1'b0;
      r_rsp_denied  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_cmd_ready <= 1'b1;
          // Reserved op is consumed without side effects; cmd_ready stays high.
          if (io_tl.cmd_valid && r_cmd_ready && (w_cmd_op != CmdRsvd)) begin
            r_cmd_ready <= 1'b0;
            r_a_valid   <= 1'b1;
            r_a_opcode  <= a_opcode_of(w_cmd_op);
            r_a_size    <= a_size_of(w_cmd_op);
            r_a_param   <= (w_cmd_op == CmdAcquire) ? io_tl.cmd_param : 3'd0;
            r_a_address <= io_tl.cmd_addr;
            r_a_mask    <= (w_cmd_op == CmdPutFull) ? io_tl.cmd_mask : 8'hFF;
            r_a_data    <= (w_cmd_op == CmdPutFull) ? io_tl.cmd_data : '0;
            r_state     <= StASend;
          end
        end
        StASend: begin
          if (io_tl.a_ready) begin
            r_a_valid <= 1'b0;
            r_d_ready <= 1'b1;
            r_wdog    <= '0;
            r_beat    <= '0;
            r_state   <= StDWait;
          end
        end
        StDWait: begin
          if (w_d_match) begin
            // Watchdog restarts on every accepted beat so a slow burst is not cut off.
            r_wdog       <= '0;
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= io_tl.d_data;
            r_rsp_denied <= io_tl.d_denied;
            if (io_tl.d_opcode == OpDGrantData) begin
              r_beat <= r_beat + 3'd1;
              if (r_beat == 3'd0) r_e_sink <= io_tl.d_sink;
              if (r_beat == 3'(BlockBeats - 1)) begin
                r_rsp_last <= 1'b1;
                r_d_ready  <= 1'b0;
                r_e_valid  <= 1'b1;
                r_state    <= StESend;
              end
            end else if (io_tl.d_opcode == OpDGrant) begin
              r_rsp_last <= 1'b1;
              r_e_sink   <= io_tl.d_sink;
              r_d_ready  <= 1'b0;
              r_e_valid  <= 1'b1;
              r_state    <= StESend;
            end else begin
              r_rsp_last  <= 1'b1;
              r_d_ready   <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= StIdle;
            end
          end else if (r_wdog == WdogW'(TIMEOUT - 1)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_last    <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_data    <= '0;
            r_beat        <= '0;
            r_d_ready     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wdog <= r_wdog + WdogW'(1);
          end
        end
        StESend: begin
          if (io_tl.e_ready) begin
            r_e_valid   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_tl.cmd_ready   = r_cmd_ready;
  assign io_tl.rsp_valid   = r_rsp_valid;
  assign io_tl.rsp_last    = r_rsp_last;
  assign io_tl.rsp_denied  = r_rsp_denied;
  assign io_tl.rsp_timeout = r_rsp_timeout;
  assign io_tl.rsp_data    = r_rsp_data;
  assign io_tl.a_valid     = r_a_valid;
  assign io_tl.a_opcode    = r_a_opcode;
  assign io_tl.a_param     = r_a_param;
  assign io_tl.a_size      = r_a_size;
  assign io_tl.a_source    = SOURCE_W'(SRC_ID);
  assign io_tl.a_address   = r_a_address;
  assign io_tl.a_mask      = r_a_mask;
  assign io_tl.a_data      = r_a_data;
  assign io_tl.d_ready     = r_d_ready;
  assign io_tl.e_valid     = r_e_valid;
  assign io_tl.e_sink      = r_e_sink;

  logic                w_b_ready;
  logic                w_c_valid;
  logic [2:0]          w_c_opcode;
  logic [2:0]          w_c_param;
  logic [3:0]          w_c_size;
  logic [SOURCE_W-1:0] w_c_source;
  logic [ADDR_W-1:0]   w_c_address;
  logic [DATA_W-1:0]   w_c_data;

  tl_probe_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SOURCE_W (SOURCE_W),
    .SRC_ID   (SRC_ID)
  ) u_probe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_b_valid   (io_tl.b_valid),
    .o_b_ready   (w_b_ready),
    .i_b_size    (io_tl.b_size),
    .i_b_address (io_tl.b_address),
    .o_c_valid   (w_c_valid),
    .i_c_ready   (io_tl.c_ready),
    .o_c_opcode  (w_c_opcode),
    .o_c_param   (w_c_param),
    .o_c_size    (w_c_size),
    .o_c_source  (w_c_source),
    .o_c_address (w_c_address),
    .o_c_data    (w_c_data)
  );

  assign io_tl.b_ready   = w_b_ready;
  assign io_tl.c_valid   = w_c_valid;
  assign io_tl.c_opcode  = w_c_opcode;
  assign io_tl.c_param   = w_c_param;
  assign io_tl.c_size    = w_c_size;
  assign io_tl.c_source  = w_c_source;
  assign io_tl.c_address = w_c_address;
  assign io_tl.c_data    = w_c_data;

endmodule

// File: tb/tb_tl_client_agent.sv
// Directed bench for tl_client_agent: a vector table of single-response transactions
// plus hand-written sequences for bursts, probes, stalls, timeout and reset.
module tb_tl_client_agent;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tl_client_agent_if #(.ADDR_W(64), .DATA_W(64), .SOURCE_W(4), .SINK_W(4)) tl ();

  tl_client_agent #(
    .ADDR_W   (64),
    .DATA_W   (64),
    .SOURCE_W (4),
    .SINK_W   (4),
    .SRC_ID   (0),
    .TIMEOUT  (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_tl (tl.master)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [2:0]  param;
    logic [2:0]  d_op;
    logic [63:0] d_data;
    logic        d_denied;
    logic [3:0]  d_sink;
    logic        bad_src_first;
    logic [2:0]  exp_a_op;
    logic [3:0]  exp_a_size;
    logic [7:0]  exp_a_mask;
    logic [63:0] exp_a_data;
    logic [2:0]  exp_a_param;
    logic        chk_data;
    logic        exp_e;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [63:0] addr,
                           input logic [63:0] data, input logic [7:0] mask,
                           input logic [2:0] param);
    int n = 0;
    while (tl.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", 64'(tl.cmd_ready), 64'd1);
    tl.cmd_valid = 1'b1;
    tl.cmd_op    = op;
    tl.cmd_addr  = addr;
    tl.cmd_data  = data;
    tl.cmd_mask  = mask;
    tl.cmd_param = param;
    tick();
    tl.cmd_valid = 1'b0;
  endtask

  task automatic wait_a_valid();
    int n = 0;
    while (tl.a_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("a_valid_wait", 64'(tl.a_valid), 64'd1);
  endtask

  task automatic a_handshake();
    tl.a_ready = 1'b1;
    tick();
    tl.a_ready = 1'b0;
    chk("a_valid_drop", 64'(tl.a_valid), 64'd0);
    chk("d_ready_up", 64'(tl.d_ready), 64'd1);
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [63:0] data, input logic [3:0] sink,
                         input logic denied, input logic [3:0] src);
    tl.d_valid  = 1'b1;
    tl.d_opcode = op;
    tl.d_data   = data;
    tl.d_sink   = sink;
    tl.d_denied = denied;
    tl.d_source = src;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tl.cmd_valid = 0; tl.cmd_op = 0; tl.cmd_addr = 0; tl.cmd_param = 0;
    tl.cmd_data = 0; tl.cmd_mask = 0; tl.a_ready = 0;
    tl.b_valid = 0; tl.b_opcode = 0; tl.b_param = 0; tl.b_size = 0; tl.b_source = 0;
    tl.b_address = 0; tl.c_ready = 0;
    tl.d_valid = 0; tl.d_opcode = 0; tl.d_param = 0; tl.d_size = 0; tl.d_source = 0;
    tl.d_sink = 0; tl.d_denied = 0; tl.d_data = 0; tl.e_ready = 0;

    vecs[0] = '{"get_1000", 2'd0, 64'h1000, 64'h0, 8'h00, 3'd0, 3'd1, 64'hDEADBEEF, 1'b0,
                4'd0, 1'b0, 3'd4, 4'd3, 8'hFF, 64'h0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{"put_1008", 2'd1, 64'h1008, 64'h1122334455667788, 8'h0F, 3'd0, 3'd0, 64'h0,
                1'b0, 4'd0, 1'b0, 3'd0, 4'd3, 8'h0F, 64'h1122334455667788, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{"get_denied", 2'd0, 64'h2000, 64'h0, 8'h00, 3'd0, 3'd1, 64'hCAFE, 1'b1,
                4'd0, 1'b1, 3'd4, 4'd3, 8'hFF, 64'h0, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{"acq_grant", 2'd2, 64'h40, 64'h0, 8'h00, 3'd2, 3'd4, 64'h0, 1'b0,
                4'd7, 1'b0, 3'd6, 4'd6, 8'hFF, 64'h0, 3'd2, 1'b0, 1'b1};

    // Reset state
    tick(); tick(); tick();
    chk("rst_cmd_ready", 64'(tl.cmd_ready), 64'd0);
    chk("rst_d_ready", 64'(tl.d_ready), 64'd0);
    chk("rst_b_ready", 64'(tl.b_ready), 64'd0);
    chk("rst_valids", 64'({tl.a_valid, tl.c_valid, tl.e_valid}), 64'd0);
    chk("rst_rsp", 64'({tl.rsp_valid, tl.rsp_last, tl.rsp_denied, tl.rsp_timeout}), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(tl.cmd_ready), 64'd1);
    chk("post_rst_b_ready", 64'(tl.b_ready), 64'd1);

    // Table-driven single-response transactions
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      issue_cmd(v.op, v.addr, v.data, v.mask, v.param);
      wait_a_valid();
      chk({v.name, "_a_opcode"}, 64'(tl.a_opcode), 64'(v.exp_a_op));
      chk({v.name, "_a_size"}, 64'(tl.a_size), 64'(v.exp_a_size));
      chk({v.name, "_a_mask"}, 64'(tl.a_mask), 64'(v.exp_a_mask));
      chk({v.name, "_a_data"}, tl.a_data, v.exp_a_data);
      chk({v.name, "_a_param"}, 64'(tl.a_param), 64'(v.exp_a_param));
      chk({v.name, "_a_address"}, tl.a_address, v.addr);
      chk({v.name, "_a_source"}, 64'(tl.a_source), 64'd0);
      a_handshake();
      if (v.bad_src_first) begin
        drive_d(3'd1, 64'h5555, 4'd0, 1'b0, 4'd5);
        tick();
        tl.d_valid = 1'b0;
        chk({v.name, "_foreign_src_ignored"}, 64'(tl.rsp_valid), 64'd0);
      end
      drive_d(v.d_op, v.d_data, v.d_sink, v.d_denied, 4'd0);
      tick();
      tl.d_valid = 1'b0;
      chk({v.name, "_rsp_valid"}, 64'(tl.rsp_valid), 64'd1);
      chk({v.name, "_rsp_last"}, 64'(tl.rsp_last), 64'd1);
      chk({v.name, "_rsp_denied"}, 64'(tl.rsp_denied), 64'(v.d_denied));
      if (v.chk_data) chk({v.name, "_rsp_data"}, tl.rsp_data, v.d_data);
      tick();
      chk({v.name, "_rsp_one_cycle"}, 64'(tl.rsp_valid), 64'd0);
      if (v.exp_e) begin
        chk({v.name, "_e_valid"}, 64'(tl.e_valid), 64'd1);
        chk({v.name, "_e_sink"}, 64'(tl.e_sink), 64'(v.d_sink));
        tl.e_ready = 1'b1;
        tick();
        tl.e_ready = 1'b0;
        chk({v.name, "_e_drop"}, 64'(tl.e_valid), 64'd0);
      end
      chk({v.name, "_cmd_ready_back"}, 64'(tl.cmd_ready), 64'd1);
    end

    // Reserved op is swallowed
    issue_cmd(2'd3, 64'h9000, 64'h0, 8'h0, 3'd0);
    chk("rsvd_cmd_ready", 64'(tl.cmd_ready), 64'd1);
    tick();
    chk("rsvd_no_a", 64'(tl.a_valid), 64'd0);

    // AcquireBlock + GrantData burst with a probe in the middle
    issue_cmd(2'd2, 64'h2040, 64'h0, 8'h0, 3'd1);
    wait_a_valid();
    chk("burst_a_opcode", 64'(tl.a_opcode), 64'd6);
    chk("burst_a_size", 64'(tl.a_size), 64'd6);
    chk("burst_a_param", 64'(tl.a_param), 64'd1);
    a_handshake();
    for (int i = 0; i < 8; i++) begin
      drive_d(3'd5, 64'(i), (i == 0) ? 4'd3 : 4'hC, 1'b0, 4'd0);
      if (i == 2) begin
        chk("probe_b_ready", 64'(tl.b_ready), 64'd1);
        tl.b_valid = 1'b1; tl.b_opcode = 3'd6; tl.b_address = 64'h3000; tl.b_size = 4'd6;
      end
      if (i == 3) begin tl.b_valid = 1'b0; tl.c_ready = 1'b1; end
      if (i == 4) tl.c_ready = 1'b0;
      tick();
      chk($sformatf("burst_rsp_valid_%0d", i), 64'(tl.rsp_valid), 64'd1);
      chk($sformatf("burst_rsp_data_%0d", i), tl.rsp_data, 64'(i));
      chk($sformatf("burst_rsp_last_%0d", i), 64'(tl.rsp_last), 64'(i == 7));
      if (i == 2) begin
        chk("probe_c_valid", 64'(tl.c_valid), 64'd1);
        chk("probe_c_opcode", 64'(tl.c_opcode), 64'd4);
        chk("probe_c_param", 64'(tl.c_param), 64'd5);
        chk("probe_c_address", tl.c_address, 64'h3000);
        chk("probe_c_size", 64'(tl.c_size), 64'd6);
        chk("probe_c_src_data", {tl.c_data[59:0], tl.c_source}, 64'd0);
      end
      if (i == 3) begin
        chk("probe_c_drop", 64'(tl.c_valid), 64'd0);
        chk("probe_b_ready_back", 64'(tl.b_ready), 64'd1);
      end
    end
    tl.d_valid = 1'b0;
    chk("burst_e_valid", 64'(tl.e_valid), 64'd1);
    chk("burst_e_sink", 64'(tl.e_sink), 64'd3);
    tick();
    chk("burst_rsp_done", 64'(tl.rsp_valid), 64'd0);
    tl.e_ready = 1'b1;
    tick();
    tl.e_ready = 1'b0;
    chk("burst_e_drop", 64'(tl.e_valid), 64'd0);

    // PutFullData with A stalled for 5 cycles
    issue_cmd(2'd1, 64'h1010, 64'hA5A5_5A5A_0123_4567, 8'h3C, 3'd0);
    wait_a_valid();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_fields_%0d", k),
          64'({tl.a_valid, tl.a_opcode, tl.a_size, tl.a_mask, tl.a_address[15:0]}),
          64'({1'b1, 3'd0, 4'd3, 8'h3C, 16'h1010}));
      chk($sformatf("stall_data_%0d", k), tl.a_data, 64'hA5A5_5A5A_0123_4567);
      tick();
    end
    a_handshake();
    drive_d(3'd0, 64'h0, 4'd0, 1'b0, 4'd0);
    tick();
    tl.d_valid = 1'b0;
    chk("put_ack_rsp", 64'({tl.rsp_valid, tl.rsp_last}), 64'b11);
    tick();
    chk("put_ack_single", 64'(tl.rsp_valid), 64'd0);

    // Watchdog timeout
    begin
      int n = 0;
      issue_cmd(2'd0, 64'h1000, 64'h0, 8'h0, 3'd0);
      wait_a_valid();
      a_handshake();
      while (tl.rsp_timeout !== 1'b1 && n < 40) begin tick(); n++; end
      chk("timeout_cycles", 64'(n), 64'd16);
      chk("timeout_rsp", 64'({tl.rsp_valid, tl.rsp_last}), 64'b11);
      chk("timeout_cmd_ready", 64'(tl.cmd_ready), 64'd1);
      tick();
      chk("timeout_pulse", 64'(tl.rsp_timeout), 64'd0);
    end

    // Reset on beat 4 of GrantData
    issue_cmd(2'd2, 64'h80, 64'h0, 8'h0, 3'd1);
    wait_a_valid();
    a_handshake();
    for (int i = 0; i < 3; i++) begin
      drive_d(3'd5, 64'h10 + 64'(i), 4'd2, 1'b0, 4'd0);
      tick();
    end
    drive_d(3'd5, 64'h13, 4'd2, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    tl.d_valid = 1'b0;
    chk("midrst_rsp", 64'({tl.rsp_valid, tl.rsp_last}), 64'd0);
    chk("midrst_valids", 64'({tl.a_valid, tl.c_valid, tl.e_valid}), 64'd0);
    chk("midrst_readies", 64'({tl.cmd_ready, tl.d_ready, tl.b_ready}), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_cmd_ready", 64'(tl.cmd_ready), 64'd1);
    issue_cmd(2'd0, 64'h1000, 64'h0, 8'h0, 3'd0);
    wait_a_valid();
    chk("after_rst_a_opcode", 64'(tl.a_opcode), 64'd4);
    a_handshake();
    drive_d(3'd1, 64'h77, 4'd0, 1'b0, 4'd0);
    tick();
    tl.d_valid = 1'b0;
    chk("after_rst_rsp", 64'({tl.rsp_valid, tl.rsp_last}), 64'b11);
    chk("after_rst_data", tl.rsp_data, 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
